// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: requester ids, FSM state
// encoding, default lock bound and the read-return tag payload.
package ram_port_arbiter_pkg;

    // Requester ids
    localparam logic PORT_MATCTRL = 1'b0;
    localparam logic PORT_HOST    = 1'b1;

    // Default maximum consecutive locked grants under contention
    localparam int unsigned LOCK_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Read-return tag: which requester a read in flight belongs to
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's access channel to the shared RAM.
//   master: the requester (drives req/we/addr/wdata/lock, receives gnt/rvalid/rdata)
//   slave : the arbiter side
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// RD_LATENCY-deep shift register of read tags, aligned with the RAM read
// latency so the tail names the owner of the ram_dout word on the bus now.
//   clk, rstn : clock, async active-low reset (clears all in-flight tags)
//   push      : tag entered on the cycle a read is issued
//   tail      : tag whose read data is on ram_dout this cycle
module rd_tag_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rstn,
    input  rd_tag_t push,
    output rd_tag_t tail
);

    rd_tag_t stage_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin on contention, optional bounded ownership lock for bursts,
// read data steered back to the issuing requester after RD_LATENCY cycles.
//   clk, rstn         : clock, async active-low reset
//   p0, p1            : requester channels (p0 = matrix controller, p1 = host)
//   ram_wr_en/rd_en   : RAM enables, asserted in the same cycle as the grant
//   ram_addr/ram_din  : RAM address / write data (hold last value when idle)
//   ram_dout          : RAM read data, valid RD_LATENCY cycles after rd_en
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned LOCK_MAX   = LOCK_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    ram_port_arbiter_if.slave     p0,
    ram_port_arbiter_if.slave     p1,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t            state_q, state_d;
    logic                  last_winner_q;
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    logic                  win_raw, win, win_id, keep_own;
    logic                  sel_we, sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  lock_sat;
    rd_tag_t               tag_push, tag_tail;

    assign lock_sat = (lock_cnt_q == CNT_W'(LOCK_MAX));

    // Winner selection, next state and RAM command
    always_comb begin
        win_raw    = 1'b0;
        win_id     = PORT_MATCTRL;
        state_d    = IDLE;
        lock_cnt_d = '0;
        keep_own   = 1'b0;

        case (state_q)
            OWN0: begin
                // Owner wins unless its lock is exhausted and the other port waits
                if (p0.req && !(lock_sat && p1.req)) begin
                    win_raw = 1'b1;
                    win_id  = PORT_MATCTRL;
                end else if (p1.req) begin
                    win_raw = 1'b1;
                    win_id  = PORT_HOST;
                end
            end
            OWN1: begin
                if (p1.req && !(lock_sat && p0.req)) begin
                    win_raw = 1'b1;
                    win_id  = PORT_HOST;
                end else if (p0.req) begin
                    win_raw = 1'b1;
                    win_id  = PORT_MATCTRL;
                end
            end
            default: begin
                if (p0.req && p1.req) begin
                    win_raw = 1'b1;
                    win_id  = ~last_winner_q;
                end else if (p0.req) begin
                    win_raw = 1'b1;
                    win_id  = PORT_MATCTRL;
                end else if (p1.req) begin
                    win_raw = 1'b1;
                    win_id  = PORT_HOST;
                end
            end
        endcase

        // Grants are forced off while reset is held
        win = win_raw & rstn;

        sel_we    = win_id ? p1.we    : p0.we;
        sel_lock  = win_id ? p1.lock  : p0.lock;
        sel_addr  = win_id ? p1.addr  : p0.addr;
        sel_wdata = win_id ? p1.wdata : p0.wdata;

        if (win && sel_lock) begin
            keep_own = ((state_q == OWN0) && (win_id == PORT_MATCTRL)) ||
                       ((state_q == OWN1) && (win_id == PORT_HOST));
            state_d  = (win_id == PORT_HOST) ? OWN1 : OWN0;
            if (!keep_own) begin
                lock_cnt_d = CNT_W'(1);
            end else if (lock_sat) begin
                lock_cnt_d = lock_cnt_q;
            end else begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end
        end
    end

    // Arbitration state, last winner and held RAM address/data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            last_winner_q <= PORT_HOST;
            lock_cnt_q    <= '0;
            addr_q        <= '0;
            din_q         <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            if (win) begin
                last_winner_q <= win_id;
                addr_q        <= sel_addr;
                din_q         <= sel_wdata;
            end
        end
    end

    assign p0.gnt    = win && (win_id == PORT_MATCTRL);
    assign p1.gnt    = win && (win_id == PORT_HOST);
    assign ram_wr_en = win && sel_we;
    assign ram_rd_en = win && !sel_we;
    assign ram_addr  = win ? sel_addr  : addr_q;
    assign ram_din   = win ? sel_wdata : din_q;

    assign tag_push.valid = ram_rd_en;
    assign tag_push.id    = win_id;

    rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk  (clk),
        .rstn (rstn),
        .push (tag_push),
        .tail (tag_tail)
    );

    // Return path: only the issuing port sees rvalid; the other keeps its rdata
    assign p0.rvalid = tag_tail.valid && (tag_tail.id == PORT_MATCTRL);
    assign p1.rvalid = tag_tail.valid && (tag_tail.id == PORT_HOST);
    assign p0.rdata  = p0.rvalid ? ram_dout : rdata0_q;
    assign p1.rdata  = p1.rvalid ? ram_dout : rdata1_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (p0.rvalid) rdata0_q <= ram_dout;
            if (p1.rvalid) rdata1_q <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural 1-cycle sync RAM, directed stimulus
// with grant checks, and a scoreboard monitor for read returns.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 64;

    logic          clk;
    logic          rstn;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int total = 0;
    int bad   = 0;
    int n0, n1;

    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    logic [DW-1:0] mem  [logic [AW-1:0]];

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (1),
        .LOCK_MAX   (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .p0        (p0_if),
        .p1        (p1_if),
        .ram_wr_en (ram_wr_en),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded RAM contents for addresses never written
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 12'h010) return 64'h0123_4567_89AB_CDEF;
        return {16'hC0DE, 36'h0, a};
    endfunction

    // Single-port synchronous RAM, read latency 1
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] = ram_din;
        if (ram_rd_en) ram_dout <= mem.exists(ram_addr) ? mem[ram_addr] : init_val(ram_addr);
    end

    task automatic report(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        report(name, {63'h0, got}, {63'h0, exp});
    endtask

    task automatic chk_addr(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        report(name, {52'h0, got}, {52'h0, exp});
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic lock);
        if (p == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata; p0_if.lock = lock;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata; p1_if.lock = lock;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic chk_gnt(input string name, input logic g0, input logic g1);
        chk_bit({name, "_gnt0"}, p0_if.gnt, g0);
        chk_bit({name, "_gnt1"}, p1_if.gnt, g1);
    endtask

    task automatic chk_all_zero(input string name);
        chk_bit({name, "_gnt0"}, p0_if.gnt, 1'b0);
        chk_bit({name, "_gnt1"}, p1_if.gnt, 1'b0);
        chk_bit({name, "_rvalid0"}, p0_if.rvalid, 1'b0);
        chk_bit({name, "_rvalid1"}, p1_if.rvalid, 1'b0);
        chk_bit({name, "_wr_en"}, ram_wr_en, 1'b0);
        chk_bit({name, "_rd_en"}, ram_rd_en, 1'b0);
        chk_addr({name, "_addr"}, ram_addr, '0);
        report({name, "_din"}, ram_din, '0);
        report({name, "_rdata0"}, p0_if.rdata, '0);
        report({name, "_rdata1"}, p1_if.rdata, '0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected read for that port
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (p0_if.rvalid) begin
            total++;
            if (exp0.size() == 0) begin
                bad++;
                $display("FAIL rvalid0_unexpected: got rdata0=%h expected no rvalid0", p0_if.rdata);
            end else begin
                e = exp0.pop_front();
                if (p0_if.rdata !== e) begin
                    bad++;
                    $display("FAIL rdata0: got %h expected %h", p0_if.rdata, e);
                end
            end
        end
        if (p1_if.rvalid) begin
            total++;
            if (exp1.size() == 0) begin
                bad++;
                $display("FAIL rvalid1_unexpected: got rdata1=%h expected no rvalid1", p1_if.rdata);
            end else begin
                e = exp1.pop_front();
                if (p1_if.rdata !== e) begin
                    bad++;
                    $display("FAIL rdata1: got %h expected %h", p1_if.rdata, e);
                end
            end
        end
    end

    initial begin
        // Reset with both ports requesting: everything must stay 0
        rstn = 1'b0;
        drive(0, 1'b1, 1'b1, 12'hABC, 64'h1234, 1'b1);
        drive(1, 1'b1, 1'b0, 12'h123, 64'h0, 1'b0);
        @(negedge clk);
        chk_all_zero("rst0");
        @(posedge clk);
        #1 idle_all();
        rstn = 1'b1;

        // T1: single port 0 read
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 12'h010, '0, 1'b0);
        @(negedge clk);
        chk_gnt("t1", 1'b1, 1'b0);
        chk_bit("t1_rd_en", ram_rd_en, 1'b1);
        chk_bit("t1_wr_en", ram_wr_en, 1'b0);
        chk_addr("t1_addr", ram_addr, 12'h010);
        exp0.push_back(64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1 idle_all();
        @(negedge clk);
        chk_bit("t1_rvalid0", p0_if.rvalid, 1'b1);
        chk_addr("t1_addr_hold", ram_addr, 12'h010);

        // T2: both ports read every cycle from reset, alternating grants
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 12'h100 + 12'(n0), '0, 1'b0);
            drive(1, 1'b1, 1'b0, 12'h200 + 12'(n1), '0, 1'b0);
            @(negedge clk);
            if (k % 2 == 0) begin
                chk_gnt("t2", 1'b1, 1'b0);
                chk_addr("t2_addr", ram_addr, 12'h100 + 12'(n0));
                exp0.push_back(init_val(12'h100 + 12'(n0)));
                n0++;
            end else begin
                chk_gnt("t2", 1'b0, 1'b1);
                chk_addr("t2_addr", ram_addr, 12'h200 + 12'(n1));
                exp1.push_back(init_val(12'h200 + 12'(n1)));
                n1++;
            end
        end
        @(posedge clk); #1 idle_all();

        // T3: port 0 locked burst of 4 against continuous port 1
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 4) drive(0, 1'b1, 1'b0, 12'h300 + 12'(k), '0, (k < 3));
            else       drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
            drive(1, 1'b1, 1'b0, 12'h210, '0, 1'b0);
            @(negedge clk);
            if (k < 4) begin
                chk_gnt("t3", 1'b1, 1'b0);
                exp0.push_back(init_val(12'h300 + 12'(k)));
            end else begin
                chk_gnt("t3_release", 1'b0, 1'b1);
                exp1.push_back(init_val(12'h210));
            end
        end
        @(posedge clk); #1 idle_all();

        // T4: port 0 lock held 20 cycles, forced release after 16 grants
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 12'h400, '0, 1'b1);
            drive(1, 1'b1, 1'b0, 12'h410, '0, 1'b0);
            @(negedge clk);
            if (k == 16) begin
                chk_gnt("t4_forced", 1'b0, 1'b1);
                exp1.push_back(init_val(12'h410));
            end else begin
                chk_gnt("t4", 1'b1, 1'b0);
                exp0.push_back(init_val(12'h400));
            end
        end
        @(posedge clk); #1 idle_all();

        // T5: port 1 write then port 0 read-back of the same address
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 12'h3FF, 64'hDEAD_BEEF_0000_0001, 1'b0);
        @(negedge clk);
        chk_gnt("t5_wr", 1'b0, 1'b1);
        chk_bit("t5_wr_en", ram_wr_en, 1'b1);
        chk_bit("t5_rd_en_w", ram_rd_en, 1'b0);
        chk_addr("t5_addr", ram_addr, 12'h3FF);
        report("t5_din", ram_din, 64'hDEAD_BEEF_0000_0001);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(0, 1'b1, 1'b0, 12'h3FF, '0, 1'b0);
        @(negedge clk);
        chk_gnt("t5_rd", 1'b1, 1'b0);
        chk_bit("t5_rd_en", ram_rd_en, 1'b1);
        chk_bit("t5_wr_en_r", ram_wr_en, 1'b0);
        exp0.push_back(64'hDEAD_BEEF_0000_0001);
        @(posedge clk); #1 idle_all();

        // T6: reset while a read is in flight
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 12'h010, '0, 1'b0);
        @(negedge clk);
        chk_gnt("t6_issue", 1'b1, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(0, 1'b1, 1'b0, 12'h020, '0, 1'b0);
        drive(1, 1'b1, 1'b0, 12'h021, '0, 1'b0);
        @(negedge clk);
        chk_all_zero("t6_rst");
        #1 rstn = 1'b1;
        #1;
        chk_gnt("t6_after", 1'b1, 1'b0);
        exp0.push_back(init_val(12'h020));
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk_gnt("t6_next", 1'b0, 1'b1);
        exp1.push_back(init_val(12'h021));
        @(posedge clk); #1 idle_all();

        // Drain: every expected read must have returned
        repeat (4) @(negedge clk);
        report("drain_exp0", 64'(exp0.size()), 64'h0);
        report("drain_exp1", 64'(exp1.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
